qpi_flash_responder: RTL and testbench
======================================

Name: qpi_flash_responder

Overview:
- Synthesizable target-side model of a Winbond-style SPI/QPI NOR flash, running in the host clock domain.
- Decodes the init, parameter and read command sequences a QPI XIP host issues, and serves read data from a byte-wide memory read port (BRAM/ROM image).
- Used as the flash stand-in on FPGA builds and as the responder in XIP controller benches.

Parameters:
- RST_CYC, 64, HCLK cycles the device stays busy after a software reset (0x66 then 0x99).
- MEM_AW, 24, memory/flash byte-address width. Upper address bits above MEM_AW are ignored.

Ports:
- HCLK  in  1  system clock; the only clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- QCS_n  in  1  flash chip select, active-low.
- QCLK_EN  in  1  high in an HCLK cycle that carries one serial-clock pulse; the bus is sampled/advanced only then.
- QIO_i  in  4  IO pins from host; SPI mode uses QIO_i[0] as SI.
- QIO_o  out  4  IO pins to host (read data nibbles).
- QIO_oe  out  1  drive enable for QIO_o.
- mem_req  out  1  one-cycle byte read request.
- mem_addr  out  MEM_AW  byte address for mem_req.
- mem_rdata  in  8  read data.
- mem_valid  in  1  mem_rdata valid; any latency of at least 1 cycle is accepted.
- qpi_mode  out  1  1 = QPI mode active.
- busy  out  1  reset busy window in progress.
- underrun  out  1  sticky; data was not ready when a nibble had to be driven.

Behaviour:
- Reset (async): QIO_o=4'hF, QIO_oe=0, mem_req=0, mem_addr=0, qpi_mode=0, busy=0, underrun=0.
- Reset also sets dummy=2 clocks, wrap=8 bytes, reset-enable latch=0, and the FSM to IDLE.
- Step definition: an HCLK edge with QCS_n=0 and QCLK_EN=1. All sampling and advancing happens only on steps.
- FSM states: IDLE, CMD, ADDR, PARAM, DUMMY, DATA, IGNORE.
- QCS_n=1 in any state forces IDLE next cycle, drops QIO_oe, and aborts the frame. An aborted PARAM write changes nothing.
- CMD phase, SPI mode: 8 steps, 1 bit each from QIO_i[0], MSB first.
- CMD phase, QPI mode: 2 steps, high nibble first.
- Command decode, SPI mode: 0x66, 0x99, 0x38. Anything else goes to IGNORE until CS rises.
- Command decode, QPI mode: 0xFF, 0x66, 0x99, 0xC0, 0x0B, 0x0C. Anything else goes to IGNORE.
- 0x66 sets the reset-enable latch. Any other completed command clears it.
- 0x99 with the latch set: revert to the reset defaults above (qpi_mode=0, dummy, wrap), then busy=1 for RST_CYC cycles.
- 0x99 without the latch set: ignored.
- While busy=1, all frames are ignored.
- 0x38 (SPI): qpi_mode=1 when CS rises.
- 0xFF (QPI): qpi_mode=0 when CS rises.
- 0xC0: PARAM, 2 nibbles forming byte P. On the 2nd nibble:
  - dummy = 2*(P[5:4]+1) clocks.
  - wrap = 8<<P[1:0] bytes.
- 0x0B / 0x0C: ADDR, 6 nibbles MSB first, then DUMMY for `dummy` steps.
- mem_req pulses on the cycle after the last address nibble, with mem_addr = address.
- DATA: each byte goes out high nibble then low nibble.
  - QIO_oe=1 and the first nibble are registered on the step that ends the last dummy clock.
  - Each later step advances one nibble.
  - The next byte is requested (mem_req) when its predecessor's high nibble is driven.
  - A nibble due with no valid byte buffered drives 4'hF and sets underrun.
- Address progression: 0x0B increments linearly, wrapping at 2^MEM_AW. 0x0C wraps within an aligned `wrap`-byte window (low log2(wrap) bits increment, upper bits held).
- DATA continues until CS rises.
- Simultaneous events: QCS_n rising has priority over QCLK_EN. A mem_valid arriving after the abort is discarded.
- Mid-frame HRESETn: immediate return to reset values.

Test Plan:
- SPI 0x66, 0x99 frames, then SPI 0x38 -> busy high exactly RST_CYC cycles after the 0x99 CS rise; qpi_mode=1 after the 0x38 CS rise.
- QPI 0xC0 with P=0x30, then 0x0B addr 0x000010 with 8 dummy steps, mem[0x10..0x13]=A5 3C 0F E1 -> QIO_o nibbles A,5,3,C,0,F,E,1; QIO_oe rises on the 8th dummy step.
- QPI 0xC0 P=0x00, then 0x0C addr 0x00000E, 4 bytes -> addresses requested 0x0E, 0x0F, 0x08, 0x09.
- Memory latency 6 cycles with dummy=2 -> first nibbles 4'hF, underrun=1 and sticky until reset.
- CS raised after 1 PARAM nibble of 0xC0 -> dummy/wrap unchanged; a following 0x0B still uses the previous dummy count.
- QPI 0xFF, then SPI 0x99 without a preceding 0x66 -> qpi_mode=0, busy never asserts; HRESETn pulsed mid-DATA -> QIO_oe=0 asynchronously.

Source files
------------

// File: rtl/qpi_flash_responder.sv
// Target-side model of a Winbond-style SPI/QPI NOR flash: decodes reset, mode,
// read-parameter and quad read frames and streams bytes from a byte-wide memory port.
module qpi_flash_responder #(
  parameter int RST_CYC = 64,
  parameter int MEM_AW  = 24
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              QCS_n,
  input  logic              QCLK_EN,
  input  logic [3:0]        QIO_i,
  output logic [3:0]        QIO_o,
  output logic              QIO_oe,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic              qpi_mode,
  output logic              busy,
  output logic              underrun
);

  localparam int BW = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_PARAM, ST_DUMMY, ST_DATA, ST_IGNORE
  } state_t;

  state_t            state_r, state_nx_s, cmd_tgt_s;
  logic [2:0]        cnt_r;
  logic [22:0]       sh_r;
  logic [23:0]       full_s;
  logic              step_s, in_cmd_s, cmd_last_s, addr_last_s, param_last_s;
  logic              dummy_last_s, phase_last_s, drive_s;
  logic              qpi_r, latch_r, rst_pend_r, on_pend_r, off_pend_r;
  logic              busy_r, wrap_mode_r;
  logic [BW-1:0]     busy_cnt_r;
  logic [3:0]        dummy_r;
  logic [1:0]        wrap_sel_r;
  logic [MEM_AW-1:0] mem_addr_r, mask_s, inc_s, next_addr_s;
  logic              mem_req_r, req_out_r, buf_vld_r, half_r, low_ok_r;
  logic              qio_oe_r, underrun_r, byte_rdy_s;
  logic [7:0]        buf_r, byte_s;
  logic [3:0]        low_r, qio_o_r;

  // full_s is the shift register with the current bus sample appended
  assign step_s       = ~QCS_n & QCLK_EN;
  assign full_s       = qpi_r ? {sh_r[19:0], QIO_i} : {sh_r[22:0], QIO_i[0]};
  assign in_cmd_s     = (state_r == ST_CMD) || ((state_r == ST_IDLE) && !busy_r);
  assign cmd_last_s   = step_s && in_cmd_s && (cnt_r == (qpi_r ? 3'd1 : 3'd7));
  assign addr_last_s  = step_s && (state_r == ST_ADDR) && (cnt_r == 3'd5);
  assign param_last_s = step_s && (state_r == ST_PARAM) && (cnt_r == 3'd1);
  assign dummy_last_s = step_s && (state_r == ST_DUMMY) && ({1'b0, cnt_r} == dummy_r - 4'd1);
  assign phase_last_s = cmd_last_s | addr_last_s | param_last_s | dummy_last_s;
  assign drive_s      = dummy_last_s || (step_s && (state_r == ST_DATA));

  // A byte returning this very cycle may be driven straight through
  assign byte_rdy_s  = buf_vld_r || (mem_valid && req_out_r);
  assign byte_s      = buf_vld_r ? buf_r : mem_rdata;
  assign mask_s      = (MEM_AW'(4'd8) << wrap_sel_r) - MEM_AW'(1'b1);
  assign inc_s       = mem_addr_r + MEM_AW'(1'b1);
  assign next_addr_s = wrap_mode_r ? ((mem_addr_r & ~mask_s) | (inc_s & mask_s)) : inc_s;

  // Command byte to follow-on phase
  always_comb begin
    cmd_tgt_s = ST_IGNORE;
    if (qpi_r) begin
      case (full_s[7:0])
        8'hC0:        cmd_tgt_s = ST_PARAM;
        8'h0B, 8'h0C: cmd_tgt_s = ST_ADDR;
        default:      cmd_tgt_s = ST_IGNORE;
      endcase
    end else begin
      cmd_tgt_s = ST_IGNORE;
    end
  end

  // Frame FSM next state
  always_comb begin
    state_nx_s = state_r;
    if (QCS_n) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nx_s = busy_r ? ST_IGNORE : ST_CMD;
        ST_CMD:    state_nx_s = cmd_last_s ? cmd_tgt_s : ST_CMD;
        ST_ADDR:   state_nx_s = addr_last_s ? ST_DUMMY : ST_ADDR;
        ST_PARAM:  state_nx_s = param_last_s ? ST_IGNORE : ST_PARAM;
        ST_DUMMY:  state_nx_s = dummy_last_s ? ST_DATA : ST_DUMMY;
        ST_DATA:   state_nx_s = ST_DATA;
        ST_IGNORE: state_nx_s = ST_IGNORE;
        default:   state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register, per-phase step counter and bus shift register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      sh_r    <= 23'd0;
    end else begin
      state_r <= state_nx_s;
      if (QCS_n) begin
        cnt_r <= 3'd0;
      end else if (step_s) begin
        cnt_r <= phase_last_s ? 3'd0 : cnt_r + 3'd1;
      end
      if (step_s) begin
        sh_r <= full_s[22:0];
      end
    end
  end

  // Mode, read parameters, reset-enable latch and post-reset busy window
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      qpi_r       <= 1'b0;
      latch_r     <= 1'b0;
      rst_pend_r  <= 1'b0;
      on_pend_r   <= 1'b0;
      off_pend_r  <= 1'b0;
      busy_r      <= 1'b0;
      busy_cnt_r  <= {BW{1'b0}};
      dummy_r     <= 4'd2;
      wrap_sel_r  <= 2'd0;
      wrap_mode_r <= 1'b0;
    end else begin
      if (QCS_n && rst_pend_r) begin
        qpi_r      <= 1'b0;
        dummy_r    <= 4'd2;
        wrap_sel_r <= 2'd0;
        busy_r     <= (RST_CYC > 0);
        busy_cnt_r <= BW'(RST_CYC - 1);
      end else begin
        if (busy_r) begin
          if (busy_cnt_r == {BW{1'b0}}) busy_r <= 1'b0;
          else busy_cnt_r <= busy_cnt_r - {{(BW-1){1'b0}}, 1'b1};
        end
        if (QCS_n && on_pend_r) qpi_r <= 1'b1;
        if (QCS_n && off_pend_r) qpi_r <= 1'b0;
      end
      if (QCS_n) begin
        rst_pend_r <= 1'b0;
        on_pend_r  <= 1'b0;
        off_pend_r <= 1'b0;
      end
      if (cmd_last_s) begin
        latch_r     <= (full_s[7:0] == 8'h66);
        rst_pend_r  <= (full_s[7:0] == 8'h99) && latch_r;
        on_pend_r   <= !qpi_r && (full_s[7:0] == 8'h38);
        off_pend_r  <= qpi_r && (full_s[7:0] == 8'hFF);
        wrap_mode_r <= (full_s[7:0] == 8'h0C);
      end
      if (param_last_s) begin
        dummy_r    <= ({2'b00, full_s[5:4]} + 4'd1) << 1;
        wrap_sel_r <= full_s[1:0];
      end
    end
  end

  // Read datapath: one outstanding fetch, one buffered byte, nibble output.
  // An underrun on a high nibble skips that slot without fetching ahead.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem_req_r  <= 1'b0;
      mem_addr_r <= {MEM_AW{1'b0}};
      req_out_r  <= 1'b0;
      buf_r      <= 8'h00;
      buf_vld_r  <= 1'b0;
      half_r     <= 1'b0;
      low_r      <= 4'h0;
      low_ok_r   <= 1'b0;
      qio_o_r    <= 4'hF;
      qio_oe_r   <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      mem_req_r <= 1'b0;
      if (QCS_n) begin
        qio_oe_r  <= 1'b0;
        qio_o_r   <= 4'hF;
        req_out_r <= 1'b0;
        buf_vld_r <= 1'b0;
        half_r    <= 1'b0;
      end else begin
        if (mem_valid && req_out_r) begin
          buf_r     <= mem_rdata;
          buf_vld_r <= 1'b1;
          req_out_r <= 1'b0;
        end
        if (addr_last_s) begin
          mem_req_r  <= 1'b1;
          mem_addr_r <= full_s[MEM_AW-1:0];
          req_out_r  <= 1'b1;
          buf_vld_r  <= 1'b0;
          half_r     <= 1'b0;
        end
        if (drive_s) begin
          qio_oe_r <= 1'b1;
          half_r   <= ~half_r;
          if (!half_r) begin
            if (byte_rdy_s) begin
              qio_o_r    <= byte_s[7:4];
              low_r      <= byte_s[3:0];
              low_ok_r   <= 1'b1;
              buf_vld_r  <= 1'b0;
              mem_req_r  <= 1'b1;
              mem_addr_r <= next_addr_s;
              req_out_r  <= 1'b1;
            end else begin
              qio_o_r    <= 4'hF;
              low_ok_r   <= 1'b0;
              underrun_r <= 1'b1;
            end
          end else if (low_ok_r) begin
            qio_o_r <= low_r;
          end else begin
            qio_o_r    <= 4'hF;
            underrun_r <= 1'b1;
          end
        end
      end
    end
  end

  assign QIO_o    = qio_o_r;
  assign QIO_oe   = qio_oe_r;
  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign qpi_mode = qpi_r;
  assign busy     = busy_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_qpi_flash_responder.sv
// Directed bench for qpi_flash_responder with a latency-programmable byte memory.
module tb_qpi_flash_responder;

  logic        HCLK = 1'b0;
  logic        HRESETn, QCS_n, QCLK_EN;
  logic [3:0]  QIO_i, QIO_o;
  logic        QIO_oe, mem_req, mem_valid, qpi_mode, busy, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  logic [7:0]  mem [256];
  logic [7:0]  vpipe = 8'h00;
  logic [23:0] apipe [8];
  logic [23:0] req_q [$];

  qpi_flash_responder #(.RST_CYC(64), .MEM_AW(24)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .QCS_n(QCS_n), .QCLK_EN(QCLK_EN),
    .QIO_i(QIO_i), .QIO_o(QIO_o), .QIO_oe(QIO_oe), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .qpi_mode(qpi_mode), .busy(busy), .underrun(underrun)
  );

  always #5 HCLK = ~HCLK;

  // memory model: answers each request exactly lat cycles later
  always @(posedge HCLK) begin
    vpipe <= {vpipe[6:0], mem_req};
    apipe[0] <= mem_addr;
    for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
    if (mem_req) req_q.push_back(mem_addr);
  end
  assign mem_valid = vpipe[lat-1];
  assign mem_rdata = mem[apipe[lat-1][7:0]];

  task automatic step(input logic [3:0] v);
    @(negedge HCLK); QIO_i = v; QCLK_EN = 1'b1;
    @(negedge HCLK); QCLK_EN = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge HCLK); QCS_n = 1'b0;
  endtask

  task automatic cs_high();
    @(negedge HCLK); QCS_n = 1'b1;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step({3'b000, b[i]});
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    step(b[7:4]); step(b[3:0]);
  endtask

  task automatic qpi_read_hdr(input logic [7:0] cmd, input logic [23:0] a);
    cs_low(); qpi_byte(cmd);
    for (int i = 5; i >= 0; i--) step(a[i*4 +: 4]);
  endtask

  task automatic test_reset();
    checks += 7;
    if (QIO_o !== 4'hF) begin failures++; $display("FAIL reset_qio_o got=%h exp=f", QIO_o); end
    if (QIO_oe !== 1'b0) begin failures++; $display("FAIL reset_qio_oe got=%b exp=0", QIO_oe); end
    if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    if (mem_addr !== 24'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL reset_qpi got=%b exp=0", qpi_mode); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_soft_reset_and_qpi_entry();
    int  cnt = 0;
    bit  seen = 1'b0;
    cs_low(); spi_byte(8'h66); cs_high(); repeat (2) @(negedge HCLK);
    cs_low(); spi_byte(8'h99); cs_high();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_before_cs_rise got=%b exp=0", busy); end
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (busy) begin cnt++; seen = 1'b1; end
      else if (seen) break;
    end
    checks++;
    if (cnt != 64) begin failures++; $display("FAIL busy_cycles got=%0d exp=64", cnt); end
    cs_low(); spi_byte(8'h38);
    checks++;
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL qpi_before_cs_rise got=%b exp=0", qpi_mode); end
    cs_high(); @(negedge HCLK);
    checks++;
    if (qpi_mode !== 1'b1) begin failures++; $display("FAIL qpi_after_38 got=%b exp=1", qpi_mode); end
  endtask

  task automatic test_fast_read();
    logic [31:0] expv = 32'hA53C0FE1;
    logic [23:0] ea;
    cs_low(); qpi_byte(8'hC0); qpi_byte(8'h30); cs_high(); @(negedge HCLK);
    req_q.delete();
    qpi_read_hdr(8'h0B, 24'h000010);
    for (int i = 0; i < 8; i++) begin
      step(4'h0);
      if (i == 6) begin
        checks++;
        if (QIO_oe !== 1'b0) begin failures++; $display("FAIL oe_dummy7 got=%b exp=0", QIO_oe); end
      end
    end
    checks++;
    if (QIO_oe !== 1'b1) begin failures++; $display("FAIL oe_dummy8 got=%b exp=1", QIO_oe); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(4'h0);
      checks++;
      if (QIO_o !== expv[31-4*k -: 4]) begin
        failures++; $display("FAIL fast_nibble%0d got=%h exp=%h", k, QIO_o, expv[31-4*k -: 4]);
      end
    end
    cs_high(); @(negedge HCLK);
    checks++;
    if (req_q.size() < 4) begin failures++; $display("FAIL fast_req_count got=%0d exp>=4", req_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        ea = 24'h000010 + 24'(k);
        checks++;
        if (req_q[k] !== ea) begin failures++; $display("FAIL fast_req%0d got=%h exp=%h", k, req_q[k], ea); end
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] expv = 32'h12345678;
    logic [31:0] expa = {8'h0E, 8'h0F, 8'h08, 8'h09};
    cs_low(); qpi_byte(8'hC0); qpi_byte(8'h00); cs_high(); @(negedge HCLK);
    req_q.delete();
    qpi_read_hdr(8'h0C, 24'h00000E);
    step(4'h0); step(4'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(4'h0);
      checks++;
      if (QIO_o !== expv[31-4*k -: 4]) begin
        failures++; $display("FAIL wrap_nibble%0d got=%h exp=%h", k, QIO_o, expv[31-4*k -: 4]);
      end
    end
    cs_high(); @(negedge HCLK);
    checks++;
    if (req_q.size() < 4) begin failures++; $display("FAIL wrap_req_count got=%0d exp>=4", req_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (req_q[k] !== {16'h0000, expa[31-8*k -: 8]}) begin
          failures++; $display("FAIL wrap_req%0d got=%h exp=%h", k, req_q[k], expa[31-8*k -: 8]);
        end
      end
    end
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL no_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_underrun();
    logic [15:0] expv = 16'hFF9A;
    lat = 6;
    repeat (10) @(negedge HCLK);
    qpi_read_hdr(8'h0B, 24'h000020);
    step(4'h0); step(4'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4'h0);
      checks++;
      if (QIO_o !== expv[15-4*k -: 4]) begin
        failures++; $display("FAIL underrun_nibble%0d got=%h exp=%h", k, QIO_o, expv[15-4*k -: 4]);
      end
    end
    cs_high(); repeat (3) @(negedge HCLK);
    checks++;
    if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
    lat = 1;
    repeat (10) @(negedge HCLK);
  endtask

  task automatic test_param_abort();
    cs_low(); qpi_byte(8'hC0); step(4'h3); cs_high(); @(negedge HCLK);
    qpi_read_hdr(8'h0B, 24'h000010);
    step(4'h0);
    checks++;
    if (QIO_oe !== 1'b0) begin failures++; $display("FAIL abort_oe_dummy1 got=%b exp=0", QIO_oe); end
    step(4'h0);
    checks += 2;
    if (QIO_oe !== 1'b1) begin failures++; $display("FAIL abort_oe_dummy2 got=%b exp=1", QIO_oe); end
    if (QIO_o !== 4'hA) begin failures++; $display("FAIL abort_nibble0 got=%h exp=a", QIO_o); end
    cs_high(); @(negedge HCLK);
    checks++;
    if (QIO_oe !== 1'b0) begin failures++; $display("FAIL cs_rise_oe got=%b exp=0", QIO_oe); end
  endtask

  task automatic test_exit_and_hard_reset();
    bit seen = 1'b0;
    cs_low(); qpi_byte(8'hFF); cs_high(); @(negedge HCLK);
    checks++;
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL qpi_after_ff got=%b exp=0", qpi_mode); end
    cs_low(); spi_byte(8'h99); cs_high();
    for (int i = 0; i < 100; i++) begin
      @(negedge HCLK);
      if (busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL busy_without_latch got=1 exp=0"); end
    cs_low(); spi_byte(8'h38); cs_high(); @(negedge HCLK);
    qpi_read_hdr(8'h0B, 24'h000010);
    step(4'h0); step(4'h0); step(4'h0);
    checks++;
    if (QIO_oe !== 1'b1) begin failures++; $display("FAIL pre_reset_oe got=%b exp=1", QIO_oe); end
    #2 HRESETn = 1'b0;
    #1;
    checks += 3;
    if (QIO_oe !== 1'b0) begin failures++; $display("FAIL async_reset_oe got=%b exp=0", QIO_oe); end
    if (QIO_o !== 4'hF) begin failures++; $display("FAIL async_reset_qio got=%h exp=f", QIO_o); end
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL async_reset_qpi got=%b exp=0", qpi_mode); end
    @(negedge HCLK); QCS_n = 1'b1; HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0; QCS_n = 1'b1; QCLK_EN = 1'b0; QIO_i = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'h0F; mem[8'h13] = 8'hE1;
    mem[8'h0E] = 8'h12; mem[8'h0F] = 8'h34; mem[8'h08] = 8'h56; mem[8'h09] = 8'h78;
    mem[8'h20] = 8'h9A;
    repeat (3) @(negedge HCLK);
    test_reset();
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    test_soft_reset_and_qpi_entry();
    test_fast_read();
    test_wrap_read();
    test_underrun();
    test_param_abort();
    test_exit_and_hard_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
